// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 data mux.
// One requester is granted at a time, each tenure is bounded by HOLD_MAX
// cycles, and the granted input is delivered on a registered output y.
module mux4_rr_arbiter #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [3:0]        gnt,
    output logic              sel0,
    output logic              sel1,
    output logic [DATA_W-1:0] y,
    output logic              y_vld,
    output logic              busy,
    output logic              timeout
);

    localparam int unsigned    HW        = $clog2(HOLD_MAX);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     owner, owner_nxt;
    logic [1:0]     ptr, ptr_nxt;
    logic [HW-1:0]  hold_cnt, hold_nxt;
    logic           timeout_nxt;

    // First asserted request found scanning upward from p, wrapping 3->0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Control state register; owner keeps the last index so sel0/sel1 hold in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            timeout  <= timeout_nxt;
        end
    end

    // Next-state logic: arbitration in IDLE, release or hold-limit cut in GRANT.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                hold_nxt = '0;
                if (|req) begin
                    state_nxt = GRANT;
                    owner_nxt = rr_pick(req, ptr);
                end
            end
            GRANT: begin
                hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
                // A voluntary release wins over the hold limit, so no timeout then.
                if (!req[owner]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = owner + 2'd1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = owner + 2'd1;
                    timeout_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        gnt = '0;
        if (state == GRANT) begin
            gnt[owner] = 1'b1;
        end
        sel0 = owner[1];
        sel1 = owner[0];
        busy = (state == GRANT);
    end

    // Registered mux output, one cycle behind the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y     <= '0;
            y_vld <= 1'b0;
        end else if (state == GRANT) begin
            y_vld <= 1'b1;
            case (owner)
                2'd0:    y <= a;
                2'd1:    y <= b;
                2'd2:    y <= c;
                default: y <= d;
            endcase
        end else begin
            y     <= '0;
            y_vld <= 1'b0;
        end
    end

endmodule
